// File: rtl/if_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage plus IF/ID pipeline register of a
//             5-stage MIPS pipeline. Owns the PC and keeps at most one
//             request outstanding to a variable-latency instruction memory.
//             It obeys the hazard-unit stalls and performs redirect and
//             flush on a taken branch or jump resolved in ID.
//  Ports    : clk, rstn (async active-low)
//             pc_write, IF_ID_write           - stall controls
//             take_branch/branch_target,
//             jump/jump_target                - redirect requests from ID
//             imem_req/imem_addr              - request to instruction memory
//             imem_valid/imem_rdata           - response from instruction memory
//             IF_ID_pc/pc_plus4/instr/valid   - IF/ID register contents
//             perf_fetch_cnt/perf_bubble_cnt  - only with IF_STAGE_PERF_EN
//  Options  : IF_STAGE_PERF_EN - adds the valid-write and bubble-write counters
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pc_write,
    input  logic        IF_ID_write,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc_plus4,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_drop;      // the outstanding response belongs to a redirected-away path
    logic [31:0] r_buf;       // response captured while the pipe was stalled
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc_plus4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic        w_adv;
    logic        w_redir;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_deliver_wait;
    logic        w_deliver_hold;
    logic        w_deliver;
    logic [31:0] w_deliver_instr;

    assign w_adv      = pc_write & IF_ID_write;
    assign w_redir    = pc_write & (take_branch | jump);
    // Branch wins when both are resolved in the same cycle
    assign w_target   = take_branch ? branch_target : jump_target;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign w_deliver_wait  = (r_state == S_WAIT) & imem_valid & ~r_drop & w_adv & ~w_redir;
    assign w_deliver_hold  = (r_state == S_HOLD) & w_adv & ~w_redir;
    assign w_deliver       = w_deliver_wait | w_deliver_hold;
    assign w_deliver_instr = w_deliver_hold ? r_buf : imem_rdata;

    // A delivering WAIT cycle immediately requests the next word so a
    // 1-cycle memory sustains one instruction per cycle.
    assign imem_req  = rstn & ((r_state == S_ISSUE) | w_deliver_wait);
    assign imem_addr = (r_state == S_ISSUE) ? r_pc : w_pc_plus4;

    // ------------------------------------------------------------------
    // Fetch state machine: PC, drop flag and hold buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_ISSUE;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
            r_buf   <= 32'd0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (w_redir) begin
                        r_pc <= w_target;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redir) begin
                        r_pc <= w_target;
                        if (imem_valid) begin
                            // Response consumed and thrown away this cycle
                            r_drop  <= 1'b0;
                            r_state <= S_ISSUE;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end else if (imem_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_ISSUE;
                        end else if (w_adv) begin
                            r_pc <= w_pc_plus4;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_redir) begin
                        r_pc    <= w_target;
                        r_state <= S_ISSUE;
                    end else if (w_adv) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= S_ISSUE;
                    end
                end
                default: begin
                    r_state <= S_ISSUE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register: deliver, flush, bubble or hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ifid_pc       <= 32'd0;
            r_ifid_pc_plus4 <= 32'd0;
            r_ifid_instr    <= NOP;
            r_ifid_valid    <= 1'b0;
        end else if (IF_ID_write) begin
            if (w_deliver) begin
                r_ifid_pc       <= r_pc;
                r_ifid_pc_plus4 <= w_pc_plus4;
                r_ifid_instr    <= w_deliver_instr;
                r_ifid_valid    <= 1'b1;
            end else begin
                // Flush and bubble look the same: pc fields keep their value
                r_ifid_instr    <= NOP;
                r_ifid_valid    <= 1'b0;
            end
        end
    end

    assign IF_ID_pc       = r_ifid_pc;
    assign IF_ID_pc_plus4 = r_ifid_pc_plus4;
    assign IF_ID_instr    = r_ifid_instr;
    assign IF_ID_valid    = r_ifid_valid;

`ifdef IF_STAGE_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_fetch  <= 32'd0;
            r_perf_bubble <= 32'd0;
        end else if (IF_ID_write) begin
            if (w_deliver) begin
                r_perf_fetch  <= r_perf_fetch + 32'd1;
            end else begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch;
    assign perf_bubble_cnt = r_perf_bubble;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage. A memory model answers each
//             request after a fixed or random latency with addr ^ 0x100.
//             A reference model tracks the architectural fetch stream (next
//             expected PC, redirected by accepted branches/jumps) and a
//             monitor compares every IF/ID update against it and against
//             the flush / bubble / hold rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;
    localparam int          C_STALL_LIMIT = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pc_write = 1'b1;
    logic        IF_ID_write = 1'b1;
    logic        take_branch = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_pc_plus4;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    if_stage #(
        .RESET_PC (C_RESET_PC),
        .NOP      (C_NOP)
    ) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .take_branch    (take_branch),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_valid    (IF_ID_valid)
`ifdef IF_STAGE_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction memory model: latest request wins, answer = addr ^ 0x100
    // ------------------------------------------------------------------
    int          mem_lat = 1;     // 0 selects a random latency of 1..3
    logic        req_seen = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] m_addr;
    int          m_cnt;

    initial forever begin
        @(negedge clk);
        req_seen = imem_req;
        req_addr = imem_addr;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt      <= 0;
            m_addr     <= 32'd0;
            imem_valid <= 1'b0;
            imem_rdata <= 32'd0;
        end else if (req_seen) begin
            m_addr <= req_addr;
            if (mem_lat == 1 || (mem_lat == 0 && $urandom_range(0, 2) == 0)) begin
                imem_valid <= 1'b1;
                imem_rdata <= req_addr ^ 32'h100;
                m_cnt      <= 0;
            end else begin
                imem_valid <= 1'b0;
                imem_rdata <= $urandom;
                m_cnt      <= (mem_lat == 0) ? int'($urandom_range(1, 2)) : mem_lat - 1;
            end
        end else if (m_cnt == 1) begin
            imem_valid <= 1'b1;
            imem_rdata <= m_addr ^ 32'h100;
            m_cnt      <= 0;
        end else begin
            imem_valid <= 1'b0;
            imem_rdata <= $urandom;
            if (m_cnt > 0) m_cnt <= m_cnt - 1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model + monitor
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];        // next PC the fetch stream must deliver
    logic        s_rstn = 1'b0, s_pcw = 1'b0, s_ifw = 1'b0, s_tb = 1'b0, s_j = 1'b0;
    logic [31:0] s_bt = 0, s_jt = 0, s_pc = 0, s_pc4 = 0, s_instr = 0;
    logic        s_valid = 1'b0;
    int          stall_cnt = 0;
    int          mdl_fetch = 0, mdl_bubble = 0;

    initial forever begin
        @(negedge clk);
        s_rstn = rstn;  s_pcw = pc_write;  s_ifw = IF_ID_write;
        s_tb = take_branch;  s_j = jump;  s_bt = branch_target;  s_jt = jump_target;
        s_pc = IF_ID_pc;  s_pc4 = IF_ID_pc_plus4;  s_instr = IF_ID_instr;  s_valid = IF_ID_valid;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (!(s_rstn && rstn)) begin
            exp_q.delete();
            exp_q.push_back(C_RESET_PC);
            stall_cnt  = 0;
            mdl_fetch  = 0;
            mdl_bubble = 0;
        end else begin
            bit          redir;
            bit          delivered;
            logic [31:0] tgt;
            logic [31:0] e;
            redir     = s_pcw && (s_tb || s_j);
            tgt       = s_tb ? s_bt : s_jt;
            delivered = 1'b0;
            if (!s_ifw) begin
                chk(IF_ID_valid == s_valid && IF_ID_instr == s_instr &&
                    IF_ID_pc == s_pc && IF_ID_pc_plus4 == s_pc4, "hold_ifid", IF_ID_pc, s_pc);
            end else if (redir) begin
                mdl_bubble++;
                chk(!IF_ID_valid && IF_ID_instr == C_NOP && IF_ID_pc == s_pc &&
                    IF_ID_pc_plus4 == s_pc4, "flush_ifid", IF_ID_instr, C_NOP);
            end else if (IF_ID_valid) begin
                mdl_fetch++;
                delivered = 1'b1;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "stream_empty", IF_ID_pc, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk(IF_ID_pc == e, "deliver_pc", IF_ID_pc, e);
                    chk(IF_ID_pc_plus4 == e + 32'd4, "deliver_pc_plus4", IF_ID_pc_plus4, e + 32'd4);
                    chk(IF_ID_instr == (e ^ 32'h100), "deliver_instr", IF_ID_instr, e ^ 32'h100);
                    exp_q.push_back(e + 32'd4);
                end
            end else begin
                mdl_bubble++;
                chk(IF_ID_instr == C_NOP && IF_ID_pc == s_pc && IF_ID_pc_plus4 == s_pc4,
                    "bubble_ifid", IF_ID_instr, C_NOP);
            end
            if (redir) begin
                exp_q.delete();
                exp_q.push_back(tgt);
            end
            // Forward progress: with the pipe free to advance, a delivery must come soon
            if (delivered || redir) begin
                stall_cnt = 0;
            end else if (s_pcw && s_ifw) begin
                stall_cnt++;
                if (stall_cnt > C_STALL_LIMIT) begin
                    chk(1'b0, "liveness", stall_cnt, C_STALL_LIMIT);
                    stall_cnt = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr, input bit want_eq, input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            #1;
            if (imem_req) begin
                found = 1'b1;
                if (want_eq) chk(imem_addr == exp_addr, name, imem_addr, exp_addr);
                else         chk(imem_addr != exp_addr, name, imem_addr, exp_addr);
            end else begin
                step();
            end
        end
        if (!found) chk(1'b0, {name, "_timeout"}, 32'd0, exp_addr);
    endtask

    task automatic chk_reset_vals(input string name);
        chk(IF_ID_valid == 1'b0,   {name, "_valid"}, IF_ID_valid, 0);
        chk(IF_ID_instr == C_NOP,  {name, "_instr"}, IF_ID_instr, C_NOP);
        chk(IF_ID_pc == 32'd0,     {name, "_pc"},    IF_ID_pc, 0);
        chk(IF_ID_pc_plus4 == 0,   {name, "_pc4"},   IF_ID_pc_plus4, 0);
        chk(imem_req == 1'b0,      {name, "_req"},   imem_req, 0);
`ifdef IF_STAGE_PERF_EN
        chk(perf_fetch_cnt == 0,   {name, "_perf_fetch"},  perf_fetch_cnt, 0);
        chk(perf_bubble_cnt == 0,  {name, "_perf_bubble"}, perf_bubble_cnt, 0);
`endif
    endtask

    logic [31:0] sv_pc;
    logic        sv_valid;

    initial begin
        #3;
        chk_reset_vals("reset");
        @(posedge clk);
        step();
        rstn = 1'b1;
        #1;
        chk(imem_req == 1'b1, "first_req", imem_req, 1);
        chk(imem_addr == C_RESET_PC, "first_req_addr", imem_addr, C_RESET_PC);

        // Streaming at 1-cycle latency: valid 2 edges after release, then 1/cycle
        step();
        chk(IF_ID_valid == 1'b0, "edge1_no_valid", IF_ID_valid, 0);
        step();
        chk(IF_ID_valid && IF_ID_pc == 32'h0, "edge2_pc0", IF_ID_pc, 32'h0);
        step();
        chk(IF_ID_valid && IF_ID_instr == 32'h104, "edge3_instr", IF_ID_instr, 32'h104);
        step();
        chk(IF_ID_valid && IF_ID_pc == 32'h8, "edge4_pc8", IF_ID_pc, 32'h8);

        // Full stall for 3 cycles while the response for 0xC arrives
        pc_write = 1'b0;  IF_ID_write = 1'b0;
        step();  step();  step();
        chk(IF_ID_valid && IF_ID_pc == 32'h8 && IF_ID_instr == 32'h108, "stall_hold", IF_ID_pc, 32'h8);
        pc_write = 1'b1;  IF_ID_write = 1'b1;
        step();
        chk(IF_ID_valid && IF_ID_pc == 32'hC && IF_ID_instr == 32'h10C, "held_delivered", IF_ID_instr, 32'h10C);
        #1;
        chk(imem_req && imem_addr == 32'h10, "resume_req", imem_addr, 32'h10);

        // Branch while a 3-cycle response is outstanding
        mem_lat = 3;
        step();
        take_branch = 1'b1;  branch_target = 32'h40;
        step();
        chk(!IF_ID_valid && IF_ID_instr == C_NOP, "branch_flush", IF_ID_instr, C_NOP);
        take_branch = 1'b0;
        mem_lat = 1;
        wait_req(32'h40, 1'b1, "branch_req_addr");

        // Branch and jump together: branch wins
        step();  step();
        take_branch = 1'b1;  jump = 1'b1;  branch_target = 32'h40;  jump_target = 32'h80;
        step();
        take_branch = 1'b0;  jump = 1'b0;
        wait_req(32'h40, 1'b1, "branch_over_jump");

        // Branch presented with pc_write=0 is ignored
        step();  step();
        sv_pc = IF_ID_pc;  sv_valid = IF_ID_valid;
        take_branch = 1'b1;  branch_target = 32'h300;  pc_write = 1'b0;  IF_ID_write = 1'b0;
        step();  step();
        chk(IF_ID_pc == sv_pc && IF_ID_valid == sv_valid, "ignored_branch", IF_ID_pc, sv_pc);
        take_branch = 1'b0;  pc_write = 1'b1;  IF_ID_write = 1'b1;
        wait_req(32'h300, 1'b0, "ignored_branch_req");

        // Randomized traffic with a mid-run reset
        mem_lat = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (i == 700) begin
                #2;
                rstn = 1'b0;
                #1;
                chk_reset_vals("reset_mid");
                pc_write = 1'b1;  IF_ID_write = 1'b1;  take_branch = 1'b0;  jump = 1'b0;
                step();  step();
                rstn = 1'b1;
                #1;
                chk(imem_req && imem_addr == C_RESET_PC, "refetch_after_reset", imem_addr, C_RESET_PC);
            end
            pc_write      = ($urandom_range(0, 9) < 8);
            IF_ID_write   = ($urandom_range(0, 9) < 8);
            take_branch   = ($urandom_range(0, 19) == 0);
            jump          = ($urandom_range(0, 19) == 0);
            branch_target = 32'($urandom_range(0, 255)) << 2;
            jump_target   = 32'($urandom_range(0, 255)) << 2;
        end

        pc_write = 1'b1;  IF_ID_write = 1'b1;  take_branch = 1'b0;  jump = 1'b0;
        repeat (10) step();
        #3;
`ifdef IF_STAGE_PERF_EN
        chk(perf_fetch_cnt == 32'(mdl_fetch), "perf_fetch", perf_fetch_cnt, 32'(mdl_fetch));
        chk(perf_bubble_cnt == 32'(mdl_bubble), "perf_bubble", perf_bubble_cnt, 32'(mdl_bubble));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and issues one-outstanding requests to instruction memory, whose response latency is variable.
- Delivers fetched instructions into IF/ID.
- Obeys the `pc_write`/`IF_ID_write` stall controls from hazard detection.
- Performs redirect and flush on taken branch or jump resolved in ID.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `NOP`, 32'h0000_0000, instruction word driven into IF/ID for bubbles and flushes.

Ports:
- `clk` input 1: the single clock.
- `rstn` input 1: reset, asynchronous and active-low.
- `pc_write` input 1: PC may advance or redirect when 1.
- `IF_ID_write` input 1: IF/ID may be updated when 1.
- `take_branch` input 1: taken branch resolved in ID.
- `branch_target` input 32: branch destination.
- `jump` input 1: jump resolved in ID.
- `jump_target` input 32: jump destination.
- `imem_req` output 1: request valid this cycle.
- `imem_addr` output 32: request address.
- `imem_valid` input 1: response valid; arrives ≥1 cycle after its request.
- `imem_rdata` input 32: response instruction.
- `IF_ID_pc` output 32: PC of the IF/ID instruction.
- `IF_ID_pc_plus4` output 32: `IF_ID_pc`+4.
- `IF_ID_instr` output 32: instruction.
- `IF_ID_valid` output 1: 0 marks a bubble.

## Operation
Definitions:
- `adv` = `pc_write` && `IF_ID_write`.
- `redir` = `pc_write` && (`take_branch` || `jump`).
- Redirect target: `branch_target` if `take_branch`, else `jump_target`. Branch has priority over jump.

State machine:
- ISSUE:
  - `imem_req`=1, `imem_addr`=pc.
  - Next state is WAIT, unless `redir`, which loads pc with the target and stays in ISSUE.
- WAIT:
  - Awaiting a response.
  - On `imem_valid` with `drop`=0 and `adv`=1 and no `redir`:
    - Write IF/ID with pc, pc+4, `imem_rdata`, valid=1.
    - pc<=pc+4.
    - Issue the next request in the same cycle: `imem_req`=1, `imem_addr`=pc+4. Stay in WAIT.
  - On `imem_valid` with `drop`=0 and `adv`=0: capture `imem_rdata` into the hold buffer and go to HOLD.
  - On `imem_valid` with `drop`=1: discard the response, clear `drop`, go to ISSUE.
- HOLD:
  - When `adv`=1 and no `redir`: write the buffer into IF/ID, pc<=pc+4, go to ISSUE.
- `redir` in any state:
  - pc<=target.
  - If `IF_ID_write`=1, IF/ID is flushed: valid=0, instr=`NOP`.
  - In WAIT with the response not arriving this cycle: set `drop`=1 and stay in WAIT.
  - In WAIT with the response arriving this cycle: discard it and go to ISSUE.
  - In HOLD: discard the buffer and go to ISSUE.
- `take_branch`/`jump` with `pc_write`=0 is ignored. ID holds the branch and re-presents it.
- When `IF_ID_write`=1 and no instruction is delivered that cycle, IF/ID takes a bubble: valid=0, instr=`NOP`, pc fields unchanged.
- When `IF_ID_write`=0, IF/ID holds all fields.
- `imem_valid` in ISSUE or HOLD is a protocol error and is ignored.

## Timing
- Reset values (asynchronous while `rstn`=0):
  - pc=`RESET_PC`, state ISSUE, `drop`=0, buffer=0.
  - `IF_ID_valid`=0, `IF_ID_instr`=`NOP`, `IF_ID_pc`=0, `IF_ID_pc_plus4`=0.
  - `imem_req` forced 0 while `rstn`=0.
- First request is in the first cycle after `rstn` rises.
- With 1-cycle memory, throughput is 1 instruction/cycle. Fetch-to-IF/ID latency is request cycle + memory latency, written at the edge ending the response cycle.
- Redirect penalty: one flushed IF/ID slot, plus any dropped outstanding response.
- Reset mid-operation abandons any outstanding request. The memory is reset by the same `rstn`.

## Configuration
- `IF_STAGE_PERF_EN` defined adds two outputs and their counters:
  - `perf_fetch_cnt` (32): counts IF/ID writes with valid=1.
  - `perf_bubble_cnt` (32): counts IF/ID writes with valid=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset then 1-cycle memory returning `instr`=addr|0x100 → IF/ID shows pc 0,4,8 with instr 0x100,0x104,0x108 on consecutive cycles; first valid appears 2 edges after reset release.
- `pc_write`=`IF_ID_write`=0 for 3 cycles while a response arrives → IF/ID unchanged for those 3 cycles, response held in HOLD; on release the held instruction is delivered, then fetch resumes at pc+4.
- `take_branch`=1, `branch_target`=0x40 with response pending 2 more cycles → IF/ID flushed (valid=0, instr=`NOP`), late response dropped, next request at 0x40.
- `take_branch`=1 and `jump`=1 in the same cycle, targets 0x40/0x80 → redirect to 0x40.
- `take_branch`=1 with `pc_write`=0 → pc and IF/ID unchanged, no flush.
- `rstn` pulsed low mid-WAIT → outputs at reset values immediately, refetch from `RESET_PC`. With `IF_STAGE_PERF_EN`, counters read 0.
